// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus responder memory and its wait-state generator.
package mips_bus_pkg;

  localparam logic [31:0] BASE_ADDR_RESET = 32'hBFC00000;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS       = 16'hB400;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  function automatic word_t merge_lanes(input word_t old_w, input word_t new_w, input be_t be);
    word_t res;
    res[7:0]   = be[0] ? new_w[7:0]   : old_w[7:0];
    res[15:8]  = be[1] ? new_w[15:8]  : old_w[15:8];
    res[23:16] = be[2] ? new_w[23:16] : old_w[23:16];
    res[31:24] = be[3] ? new_w[31:24] : old_w[31:24];
    return res;
  endfunction

endpackage

// File: rtl/mips_bus_ram_if.sv
// Avalon-style word bus between the CPU initiator (master) and a memory responder (slave).
interface mips_bus_ram_if;
  import mips_bus_pkg::*;

  word_t address;
  logic  write;
  logic  read;
  logic  waitrequest;
  word_t writedata;
  be_t   byteenable;
  word_t readdata;
  logic  error;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata, error
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata, error
  );

endinterface

// File: rtl/mips_bus_lfsr.sv
// 16-bit Fibonacci LFSR used as a pseudo-random wait-state source for bus models.
module mips_bus_lfsr
  import mips_bus_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  // Shift register advancing on every non-reset cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/mips_bus_ram.sv
// Bus responder memory for mips_cpu_bus: word array mapped at BASE_ADDR with fixed or LFSR-driven wait states.
module mips_bus_ram
  import mips_bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_RESET,
  parameter int          WAIT_STATES = 0,
  parameter int          RANDOM_WAIT = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter string       INIT_FILE   = ""
) (
  input  logic         clk,
  input  logic         reset,
  mips_bus_ram_if.slave bus
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  FIXED_TGT = 2'(WAIT_STATES);
  localparam logic [29:0] DEPTH_30  = 30'(DEPTH_WORDS);

  word_t  r_mem [DEPTH_WORDS];
  state_t r_state, w_state_nxt;
  logic [1:0] r_cnt, w_cnt_nxt, r_tgt, w_tgt_nxt, w_tgt;
  word_t  r_readdata;
  logic   r_error;
  logic [15:0] w_lfsr;
  logic   w_req, w_illegal, w_wait, w_accept, w_in_range, w_zero_addr;
  word_t  w_offset;
  logic [IDX_W-1:0] w_idx;
  logic   w_unused_ok;

  // Memory image is a simulation/FPGA power-up value; reset never touches it
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] = 32'h0;
  end

  mips_bus_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .o_lfsr (w_lfsr)
  );

  assign w_req       = bus.read ^ bus.write;
  assign w_illegal   = bus.read & bus.write;
  assign w_tgt       = (RANDOM_WAIT != 0) ? w_lfsr[1:0] : FIXED_TGT;
  assign w_offset    = bus.address - BASE_ADDR;
  assign w_idx       = w_offset[IDX_W+1:2];
  assign w_in_range  = (w_offset[31:2] < DEPTH_30);
  assign w_zero_addr = (bus.address == 32'h0);
  assign w_accept    = w_req & ~w_wait;
  assign w_unused_ok = ^{w_offset[1:0], w_lfsr[15:2]};

  // Wait-state sequencing: next state, counter, stored target and waitrequest
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt;
    w_wait      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && (w_tgt != 2'd0)) begin
          w_wait      = 1'b1;
          w_state_nxt = STALL;
          w_cnt_nxt   = 2'd1;
          w_tgt_nxt   = w_tgt;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      STALL: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 2'd0;
        end else if (r_cnt < r_tgt) begin
          w_wait    = 1'b1;
          w_cnt_nxt = r_cnt + 2'd1;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 2'd0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_tgt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  // Registered read data and one-cycle error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= 32'h0;
      r_error    <= 1'b0;
    end else begin
      r_error <= w_illegal | (w_accept & ~w_in_range & ~w_zero_addr);
      if (w_accept && bus.read) begin
        r_readdata <= w_in_range ? r_mem[w_idx] : 32'h0;
      end
    end
  end

  // Byte-lane write on acceptance; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (!reset && w_accept && bus.write && w_in_range) begin
      r_mem[w_idx] <= merge_lanes(r_mem[w_idx], bus.writedata, bus.byteenable);
    end
  end

  assign bus.waitrequest = w_wait;
  assign bus.readdata    = r_readdata;
  assign bus.error       = r_error;

endmodule

// File: tb/tb_mips_bus_ram.sv
// Scoreboard bench for mips_bus_ram: three instances with 0, 3 and 2 fixed wait states.
module tb_mips_bus_ram;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_s   [3];
  logic [31:0] addr_s  [3];
  logic        rd_s    [3];
  logic        wr_s    [3];
  logic [31:0] wdata_s [3];
  logic [3:0]  be_s    [3];
  logic        wreq_s  [3];
  logic [31:0] rdata_s [3];
  logic        err_s   [3];

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_bus_ram_if bus ();
    assign bus.address    = addr_s[g];
    assign bus.read       = rd_s[g];
    assign bus.write      = wr_s[g];
    assign bus.writedata  = wdata_s[g];
    assign bus.byteenable = be_s[g];
    assign wreq_s[g]      = bus.waitrequest;
    assign rdata_s[g]     = bus.readdata;
    assign err_s[g]       = bus.error;

    mips_bus_ram #(
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .clk   (clk),
      .reset (rst_s[g]),
      .bus   (bus.slave)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_bus(input int sel);
    rd_s[sel]    = 1'b0;
    wr_s[sel]    = 1'b0;
    addr_s[sel]  = 32'h0;
    wdata_s[sel] = 32'h0;
    be_s[sel]    = 4'h0;
  endtask

  // Full transaction: push the expectation, drive, count stalls, pop and compare after acceptance
  task automatic do_access(input int sel, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] exp_rd, input logic exp_err, input int exp_waits);
    exp_t e;
    int   waits;
    e.chk_rd = rd & ~wr;
    e.rdata  = exp_rd;
    e.err    = exp_err;
    sb_q.push_back(e);
    addr_s[sel]  = addr;
    rd_s[sel]    = rd;
    wr_s[sel]    = wr;
    wdata_s[sel] = wd;
    be_s[sel]    = be;
    waits = 0;
    #1;
    while (wreq_s[sel] && waits < 10) begin
      @(posedge clk);
      #1;
      waits++;
    end
    check_eq($sformatf("waits@%h", addr), 32'(waits), 32'(exp_waits));
    @(posedge clk);
    #1;
    idle_bus(sel);
    e = sb_q.pop_front();
    if (e.chk_rd) check_eq($sformatf("rdata@%h", addr), rdata_s[sel], e.rdata);
    check_eq($sformatf("err@%h", addr), 32'(err_s[sel]), 32'(e.err));
    @(posedge clk);
    #1;
    check_eq($sformatf("err_clr@%h", addr), 32'(err_s[sel]), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b1;
      idle_bus(i);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_rdata", rdata_s[i], 32'h0);
      check_eq("rst_err", 32'(err_s[i]), 32'h0);
      check_eq("rst_wait", 32'(wreq_s[i]), 32'h0);
    end

    // Zero wait states: write/read, byte lanes, empty byteenable
    do_access(0, 1'b0, 1'b1, 32'hBFC00030, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    do_access(0, 1'b1, 1'b0, 32'hBFC00030, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    do_access(0, 1'b0, 1'b1, 32'hBFC0000C, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
    do_access(0, 1'b0, 1'b1, 32'hBFC0000C, 32'h0000AB00, 4'b0010, 32'h0, 1'b0, 0);
    do_access(0, 1'b1, 1'b0, 32'hBFC0000F, 32'h0, 4'h0, 32'h1122AB44, 1'b0, 0);
    do_access(0, 1'b0, 1'b1, 32'hBFC0000C, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 0);
    do_access(0, 1'b1, 1'b0, 32'hBFC0000C, 32'h0, 4'h0, 32'h1122AB44, 1'b0, 0);

    // Range handling: just past the end, address zero, out-of-range write not aliasing
    do_access(0, 1'b1, 1'b0, 32'hBFC00100, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    do_access(0, 1'b1, 1'b0, 32'hBFC000FC, 32'h0, 4'h0, 32'h0, 1'b0, 0);
    do_access(0, 1'b1, 1'b0, 32'hBFC00030, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    do_access(0, 1'b1, 1'b0, 32'h00000000, 32'h0, 4'h0, 32'h0, 1'b0, 0);
    do_access(0, 1'b0, 1'b1, 32'hBFC00100, 32'h55555555, 4'hF, 32'h0, 1'b1, 0);
    do_access(0, 1'b0, 1'b1, 32'h00000000, 32'h66666666, 4'hF, 32'h0, 1'b0, 0);
    do_access(0, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    // Illegal read+write: no access, error pulse, previous readdata kept
    do_access(0, 1'b1, 1'b0, 32'hBFC00030, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    do_access(0, 1'b1, 1'b1, 32'hBFC00030, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
    check_eq("illegal_keep_rd", rdata_s[0], 32'hDEADBEEF);
    do_access(0, 1'b1, 1'b0, 32'hBFC00030, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

    // Three wait states, then an aborted read
    do_access(1, 1'b0, 1'b1, 32'hBFC00000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 3);
    do_access(1, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 3);
    addr_s[1] = 32'hBFC00004;
    rd_s[1]   = 1'b1;
    #1;
    check_eq("abort_wait0", 32'(wreq_s[1]), 32'h1);
    @(posedge clk);
    #1;
    check_eq("abort_wait1", 32'(wreq_s[1]), 32'h1);
    idle_bus(1);
    #1;
    check_eq("abort_drop", 32'(wreq_s[1]), 32'h0);
    @(posedge clk);
    #1;
    check_eq("abort_rdata", rdata_s[1], 32'hCAFEF00D);
    check_eq("abort_err", 32'(err_s[1]), 32'h0);
    do_access(1, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 3);

    // Two wait states with reset landing on the second stall cycle
    do_access(2, 1'b0, 1'b1, 32'hBFC00014, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 2);
    do_access(2, 1'b1, 1'b0, 32'hBFC00014, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 2);
    addr_s[2]  = 32'hBFC00014;
    wdata_s[2] = 32'h12345678;
    be_s[2]    = 4'hF;
    wr_s[2]    = 1'b1;
    #1;
    check_eq("rst_stall_a", 32'(wreq_s[2]), 32'h1);
    @(posedge clk);
    #1;
    check_eq("rst_stall_b", 32'(wreq_s[2]), 32'h1);
    rst_s[2] = 1'b1;
    @(posedge clk);
    #1;
    rst_s[2] = 1'b0;
    idle_bus(2);
    #1;
    check_eq("midrst_rdata", rdata_s[2], 32'h0);
    check_eq("midrst_wait", 32'(wreq_s[2]), 32'h0);
    check_eq("midrst_err", 32'(err_s[2]), 32'h0);
    do_access(2, 1'b1, 1'b0, 32'hBFC00014, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 2);

    check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
